cmp_mask_pack: RTL and testbench
================================

# cmp_mask_pack

Mask packer that sits directly downstream of the vector comparator. It takes one per-element compare result per cycle for vmseq/vmsne/vmslt/vmsle/vmsgt-class ops, packs the bits into MASK_WIDTH-bit mask words, and sends each word to the register-file write port over a valid/ready handshake. It handles vl, v0 masking and tail bits, so the comparator itself stays purely combinational.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the comparator result bus
- MASK_WIDTH, 32, bits per emitted mask word (power of two)
- VL_WIDTH, 10, width of the vector length and element counters

Ports:
- module_clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse that begins an op; sampled only in IDLE
- vl_i  in  VL_WIDTH  element count, latched on start_i
- elem_valid_i  in  1  element result valid
- elem_ready_o  out  1  packer accepts an element this cycle
- cmp_result_i  in  DATA_WIDTH  comparator output; only bit 0 is used (comparator outputs are all-ones or all-zeros)
- elem_active_i  in  1  v0 mask bit for this element (1 = active)
- old_mask_i  in  MASK_WIDTH  prior destination word at the current word index; used only with the macro
- word_valid_o  out  1  packed word available
- word_ready_i  in  1  consumer takes the word
- word_data_o  out  MASK_WIDTH  packed mask word
- word_idx_o  out  VL_WIDTH  index of the word (element index / MASK_WIDTH)
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at the end of the op

## Operation
FSM states:
- **IDLE**
  - start_i with vl_i != 0: latch vl, clear bit_cnt, elem_cnt, word_idx and the buffer; go to PACK.
  - start_i with vl_i == 0: go to DONE.
- **PACK**
  - elem_ready_o = 1.
  - On elem_valid_i & elem_ready_o:
    - buf[bit_cnt] = elem_active_i ? cmp_result_i[0] : inactive_fill(bit_cnt).
    - bit_cnt++ and elem_cnt++.
  - If the accepted element makes bit_cnt == MASK_WIDTH, or makes elem_cnt == vl, go to EMIT.
- **EMIT**
  - word_valid_o = 1 and elem_ready_o = 0.
  - word_data_o = buf, with bits at index >= bit_cnt replaced by tail_fill.
  - On word_ready_i:
    - If elem_cnt == vl, go to DONE.
    - Otherwise clear buf and bit_cnt, word_idx++, go to PACK.
- **DONE**: done_o = 1 for one cycle, then go to IDLE.

Other rules:
- start_i outside IDLE is ignored.
- elem_valid_i outside PACK is ignored; elem_ready_o is 0 there.
- Counters never wrap within an op, since vl <= 2^VL_WIDTH - 1. elem_cnt is compared for equality only.
- Inactive-bit and tail fill values are set by the macro (see Configuration).

## Timing
- Reset values: elem_ready_o=0, word_valid_o=0, word_data_o=0, word_idx_o=0, busy_o=0, done_o=0; state = IDLE.
- start_i in cycle t puts the block in PACK at t+1 (elem_ready_o=1), or in DONE at t+1 if vl=0.
- Throughput is one element per cycle within a word.
- The last accepted element of a word (cycle t) makes word_valid_o high at t+1. This costs one bubble per word.
- word_data_o and word_idx_o are registered and stay stable while word_valid_o=1 and word_ready_i=0.
- When word_ready_i is seen with the final word in cycle t, done_o=1 at t+1.
- rst_ni asserted mid-op: all state clears immediately. No partial word and no done_o are emitted.

## Configuration
- CMP_MASK_UNDISTURBED_EN
  - Defined (mask-undisturbed, tail-undisturbed): inactive_fill(i) = old_mask_i[i] and tail_fill(i) = old_mask_i[i]. old_mask_i is sampled combinationally at accept time for inactive bits and in EMIT for tail bits. The upstream side holds old_mask_i stable for the current word_idx_o.
  - Undefined (agnostic): inactive and tail bits are written as 1. old_mask_i is unused.

## Test plan
- vl=5, all elements active, results 1,0,1,1,0 -> one word, idx 0, data 0xFFFFFFED without the macro; with the macro and old_mask_i=0 -> 0x0000000D. done_o follows one cycle after the handshake.
- vl=40, alternating results 1,0 -> word 0 = 0x55555555 at idx 0; word 1 at idx 1 = 0xFFFFFF55 without the macro, 0x00000055 with the macro and old_mask_i=0.
- vl=0 start -> done_o at t+1, word_valid_o never asserts, busy_o high for exactly one cycle.
- vl=32 with word_ready_i held low for 3 cycles -> word_valid_o stays high, word_data_o stays stable, elem_ready_o=0 throughout; a single transfer on the 4th cycle.
- vl=4, elem_active_i=0 on element 2, result 1 everywhere -> bit 2 = 1 without the macro; with the macro and old_mask_i=0 -> bit 2 = 0, data 0x0000000B.
- vl=40, rst_ni pulsed low after 10 elements -> outputs return to reset values with no word and no done_o; a fresh start with vl=3 then works normally.

Source files
------------

// File: rtl/cmp_mask_pack.sv
// Packs one compare bit per cycle into MASK_WIDTH-bit mask words; one bubble per word (EMIT cycle), done_o one cycle after the final word handshake.
// Elements stall (elem_ready_o=0) while a word waits on word_ready_i; define CMP_MASK_UNDISTURBED_EN for mask/tail-undisturbed fill from old_mask_i.
module cmp_mask_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 32,
  parameter int VL_WIDTH   = 10
) (
  input  logic                  module_clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [VL_WIDTH-1:0]   vl_i,
  input  logic                  elem_valid_i,
  output logic                  elem_ready_o,
  input  logic [DATA_WIDTH-1:0] cmp_result_i,
  input  logic                  elem_active_i,
  input  logic [MASK_WIDTH-1:0] old_mask_i,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [MASK_WIDTH-1:0] word_data_o,
  output logic [VL_WIDTH-1:0]   word_idx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IW = $clog2(MASK_WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_EMIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [VL_WIDTH-1:0]   vl_q, elem_cnt_q, word_idx_q;
  logic [VL_WIDTH-1:0]   elem_cnt_inc;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_inc;
  logic [IW-1:0]         bit_idx;
  logic [MASK_WIDTH-1:0] pack_q;
  logic                  all_done;
  logic                  fill_bit;
  logic                  new_bit;

  assign elem_cnt_inc = elem_cnt_q + VL_WIDTH'(1);
  assign bit_cnt_inc  = bit_cnt_q + CW'(1);
  assign bit_idx      = bit_cnt_q[IW-1:0];
  assign all_done     = (elem_cnt_q == vl_q);

`ifdef CMP_MASK_UNDISTURBED_EN
  // Undisturbed: clear to 0 and let old_mask_i supply inactive and tail bits.
  localparam logic [MASK_WIDTH-1:0] CLEAR_VAL = '0;
  assign fill_bit = old_mask_i[bit_idx];

  always_comb begin
    word_data_o = pack_q;
    if (state_q == S_EMIT) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (CW'(i) >= bit_cnt_q) word_data_o[i] = old_mask_i[i];
      end
    end
  end

  logic unused_in;
  assign unused_in = ^cmp_result_i[DATA_WIDTH-1:1];
`else
  // Agnostic: clearing to all-ones makes unwritten tail bits come out as 1.
  localparam logic [MASK_WIDTH-1:0] CLEAR_VAL = '1;
  assign fill_bit    = 1'b1;
  assign word_data_o = pack_q;

  logic unused_in;
  assign unused_in = ^{cmp_result_i[DATA_WIDTH-1:1], old_mask_i};
`endif

  assign new_bit    = elem_active_i ? cmp_result_i[0] : fill_bit;
  assign word_idx_o = word_idx_q;

  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (vl_i == '0) ? S_DONE : S_PACK;
      end
      S_PACK: begin
        if (elem_valid_i && ((bit_cnt_inc == CW'(MASK_WIDTH)) || (elem_cnt_inc == vl_q)))
          state_d = S_EMIT;
      end
      S_EMIT: begin
        if (word_ready_i) state_d = all_done ? S_DONE : S_PACK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    elem_ready_o = (state_q == S_PACK);
    word_valid_o = (state_q == S_EMIT);
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
  end

  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vl_q       <= '0;
      elem_cnt_q <= '0;
      word_idx_q <= '0;
      bit_cnt_q  <= '0;
      pack_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            vl_q       <= vl_i;
            elem_cnt_q <= '0;
            word_idx_q <= '0;
            bit_cnt_q  <= '0;
            pack_q     <= CLEAR_VAL;
          end
        end
        S_PACK: begin
          if (elem_valid_i) begin
            pack_q[bit_idx] <= new_bit;
            bit_cnt_q       <= bit_cnt_inc;
            elem_cnt_q      <= elem_cnt_inc;
          end
        end
        S_EMIT: begin
          if (word_ready_i && !all_done) begin
            pack_q     <= CLEAR_VAL;
            bit_cnt_q  <= '0;
            word_idx_q <= word_idx_q + VL_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_mask_pack.sv
// Bench for cmp_mask_pack: directed scenarios plus randomized ops scored against a word-level reference.
module tb_cmp_mask_pack;
  localparam int DW = 32;
  localparam int MW = 32;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [VW-1:0] vl_i;
  logic          elem_valid_i;
  logic          elem_ready_o;
  logic [DW-1:0] cmp_result_i;
  logic          elem_active_i;
  logic [MW-1:0] old_mask_i;
  logic          word_valid_o;
  logic          word_ready_i;
  logic [MW-1:0] word_data_o;
  logic [VW-1:0] word_idx_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int failures = 0;

  bit            res [1024];
  bit            act [1024];
  logic [MW-1:0] old_words [64];
  logic [MW-1:0] exp_words [$];
  logic [MW-1:0] got_words [$];

  // Upstream presents the prior destination word for whichever index is being built.
  assign old_mask_i = old_words[word_idx_o[5:0]];

  cmp_mask_pack #(.DATA_WIDTH(DW), .MASK_WIDTH(MW), .VL_WIDTH(VW)) dut (
    .module_clk_i (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .vl_i         (vl_i),
    .elem_valid_i (elem_valid_i),
    .elem_ready_o (elem_ready_o),
    .cmp_result_i (cmp_result_i),
    .elem_active_i(elem_active_i),
    .old_mask_i   (old_mask_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_idx_o   (word_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fill_bit(input int w, input int i);
`ifdef CMP_MASK_UNDISTURBED_EN
    return old_words[w][i];
`else
    return 1'b1;
`endif
  endfunction

  // Reference: word w holds elements w*MW .. w*MW+MW-1; inactive/tail bits take the fill value.
  task automatic build_model(input int vl);
    logic [MW-1:0] word;
    int nw;
    exp_words.delete();
    nw = (vl + MW - 1) / MW;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int i = 0; i < MW; i++) begin
        int e;
        e = w * MW + i;
        if (e < vl) word[i] = act[e] ? logic'(res[e]) : fill_bit(w, i);
        else        word[i] = fill_bit(w, i);
      end
      exp_words.push_back(word);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_elem_ready"}, elem_ready_o, 0);
    check({tag, "_word_valid"}, word_valid_o, 0);
    check({tag, "_word_data"},  word_data_o,  0);
    check({tag, "_word_idx"},   word_idx_o,   0);
    check({tag, "_busy"},       busy_o,       0);
    check({tag, "_done"},       done_o,       0);
  endtask

  // ready_mode 0: random word_ready_i; 1: hold ready low for 3 valid cycles, then take it.
  task automatic run_op(input int vl, input int p_valid, input int ready_mode, input bit rand_start);
    int  e, w, cyc, stall, nw, idx;
    bit  exp_ready, exp_valid, exp_done, n_ready, n_valid, n_done, finished;
    e = 0; w = 0; cyc = 0; stall = 0; finished = 0;
    nw = (vl + MW - 1) / MW;
    build_model(vl);
    got_words.delete();
    start_i = 1'b1;
    vl_i    = VW'(vl);
    step();
    start_i   = 1'b0;
    exp_ready = (vl != 0);
    exp_valid = 1'b0;
    exp_done  = (vl == 0);
    while (!finished && cyc < 3000) begin
      check("elem_ready", elem_ready_o, exp_ready);
      check("word_valid", word_valid_o, exp_valid);
      check("done",       done_o,       exp_done);
      check("busy",       busy_o,       1);
      if (exp_done) begin
        finished = 1'b1;
      end else begin
        if (exp_valid && w < nw) begin
          check("word_data", word_data_o, exp_words[w]);
          check("word_idx",  word_idx_o,  w);
        end
        elem_valid_i  = exp_ready ? ($urandom_range(0, 99) < p_valid) : 1'($urandom_range(0, 1));
        idx           = (e < vl) ? e : 0;
        cmp_result_i  = res[idx] ? '1 : '0;
        elem_active_i = act[idx];
        word_ready_i  = (ready_mode == 1) ? (stall >= 3) : ($urandom_range(0, 99) < 60);
        start_i       = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        vl_i          = VW'($urandom);
        n_ready = exp_ready; n_valid = exp_valid; n_done = 1'b0;
        if (exp_ready && elem_valid_i) begin
          e++;
          if ((e % MW) == 0 || e == vl) begin
            n_ready = 1'b0;
            n_valid = 1'b1;
          end
        end
        if (exp_valid) begin
          if (word_ready_i) begin
            got_words.push_back(word_data_o);
            w++;
            stall   = 0;
            n_valid = 1'b0;
            if (w == nw) n_done = 1'b1;
            else         n_ready = 1'b1;
          end else begin
            stall++;
          end
        end
        exp_ready = n_ready; exp_valid = n_valid; exp_done = n_done;
        step();
        cyc++;
      end
    end
    check("op_finished_in_budget", finished, 1);
    start_i = 1'b0; elem_valid_i = 1'b0; word_ready_i = 1'b0;
    check("elem_count", e, vl);
    check("word_count", w, nw);
    step();
    check("post_busy",       busy_o,       0);
    check("post_done",       done_o,       0);
    check("post_word_valid", word_valid_o, 0);
    check("post_elem_ready", elem_ready_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; vl_i = '0; elem_valid_i = 1'b0;
    cmp_result_i = '0; elem_active_i = 1'b0; word_ready_i = 1'b0;
    for (int i = 0; i < 64; i++) old_words[i] = '0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // vl=5, results 1,0,1,1,0
    for (int i = 0; i < 8; i++) act[i] = 1'b1;
    res[0] = 1; res[1] = 0; res[2] = 1; res[3] = 1; res[4] = 0;
    run_op(5, 100, 0, 0);
`ifdef CMP_MASK_UNDISTURBED_EN
    check("tp_vl5_word", got_words[0], 32'h0000000D);
`else
    check("tp_vl5_word", got_words[0], 32'hFFFFFFED);
`endif

    // vl=40, alternating 1,0
    for (int i = 0; i < 40; i++) begin res[i] = (i % 2 == 0); act[i] = 1'b1; end
    run_op(40, 100, 0, 0);
    check("tp_vl40_word0", got_words[0], 32'h55555555);
`ifdef CMP_MASK_UNDISTURBED_EN
    check("tp_vl40_word1", got_words[1], 32'h00000055);
`else
    check("tp_vl40_word1", got_words[1], 32'hFFFFFF55);
`endif

    // vl=0: straight to DONE
    run_op(0, 100, 0, 0);
    check("tp_vl0_no_words", got_words.size(), 0);

    // vl=32 with consumer stalling 3 cycles
    for (int i = 0; i < 32; i++) begin res[i] = 1'($urandom); act[i] = 1'b1; end
    run_op(32, 100, 1, 0);
    check("tp_stall_one_word", got_words.size(), 1);

    // vl=4, element 2 inactive, all results 1
    for (int i = 0; i < 4; i++) begin res[i] = 1'b1; act[i] = 1'b1; end
    act[2] = 1'b0;
    run_op(4, 100, 0, 0);
`ifdef CMP_MASK_UNDISTURBED_EN
    check("tp_inactive_word", got_words[0], 32'h0000000B);
`else
    check("tp_inactive_word", got_words[0], 32'hFFFFFFFF);
`endif
    act[2] = 1'b1;

    // vl=40, reset after 10 elements
    start_i = 1'b1; vl_i = VW'(40);
    step();
    start_i = 1'b0; elem_valid_i = 1'b1; cmp_result_i = '1; elem_active_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("midop_no_word", word_valid_o, 0);
      check("midop_no_done", done_o, 0);
      step();
    end
    rst_n = 1'b0; elem_valid_i = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    step();
    check("midop_no_done_in_reset", done_o, 0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin res[i] = 1'($urandom); act[i] = 1'($urandom); end
    run_op(3, 100, 0, 0);

    // Randomized ops with random v0 masks, old words, stray start pulses and backpressure
    for (int n = 0; n < 20; n++) begin
      int vl;
      vl = (n % 7 == 6) ? 0 : $urandom_range(1, 100);
      for (int i = 0; i < 64; i++) old_words[i] = $urandom;
      for (int i = 0; i < vl; i++) begin res[i] = 1'($urandom); act[i] = ($urandom_range(0, 3) != 0); end
      run_op(vl, 70, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
